fpnew_opgroup_dispatcher: RTL and testbench

FPNEW_OPGROUP_DISPATCHER -- requirements
Module: fpnew_opgroup_dispatcher

---
 rtl/fpnew_opgroup_dispatcher.sv | 166 ++++++++++++++++
 tb/tb_fpnew_opgroup_dispatcher.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fpnew_opgroup_dispatcher.sv
// fpnew_opgroup_dispatcher
//
// Shares one FPU opgroup block between NumReq requesters. Operations are
// issued with zero latency through a round-robin arbiter that skips any
// requester that has already used up its outstanding-operation credits.
// Results come back tagged with the requester ID and are routed
// combinationally to that requester's response port.
//
// Ports:
//   clk_i, rst_ni                   clock, asynchronous active-low reset
//   req_valid_i/req_ready_o         per-requester issue handshake
//   req_data_i                      per-requester packed operation payload
//   fpu_valid_o/fpu_ready_i         issue handshake towards the opgroup block
//   fpu_data_o, fpu_tag_o           issued payload and requester ID
//   fpu_out_valid_i/fpu_out_ready_o result handshake from the opgroup block
//   fpu_result_i, fpu_tag_i         returned result and its requester ID
//   rsp_valid_o/rsp_ready_i         per-requester response handshake
//   rsp_data_o                      response payload shared by all requesters
//   flush_i                         synchronous flush of all credit counters
//   busy_o                          at least one operation outstanding
//   err_o                           sticky flag: bad tag or unexpected result
module fpnew_opgroup_dispatcher #(
  parameter int unsigned NumReq         = 2,
  parameter int unsigned PayloadWidth   = 128,
  parameter int unsigned ResWidth       = 38,
  parameter int unsigned MaxOutstanding = 4,
  localparam int unsigned IdWidth       = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic [NumReq-1:0]                   req_valid_i,
  output logic [NumReq-1:0]                   req_ready_o,
  input  logic [NumReq-1:0][PayloadWidth-1:0] req_data_i,
  output logic                                fpu_valid_o,
  input  logic                                fpu_ready_i,
  output logic [PayloadWidth-1:0]             fpu_data_o,
  output logic [IdWidth-1:0]                  fpu_tag_o,
  input  logic                                fpu_out_valid_i,
  output logic                                fpu_out_ready_o,
  input  logic [ResWidth-1:0]                 fpu_result_i,
  input  logic [IdWidth-1:0]                  fpu_tag_i,
  output logic [NumReq-1:0]                   rsp_valid_o,
  input  logic [NumReq-1:0]                   rsp_ready_i,
  output logic [ResWidth-1:0]                 rsp_data_o,
  input  logic                                flush_i,
  output logic                                busy_o,
  output logic                                err_o
);

  localparam int unsigned CntWidth = $clog2(MaxOutstanding + 1);
  typedef logic [CntWidth-1:0] cnt_t;
  localparam cnt_t MaxCnt = cnt_t'(MaxOutstanding);

  cnt_t [NumReq-1:0]  cnt_q, cnt_d;
  logic [IdWidth-1:0] rr_q, rr_d;
  logic               err_q, err_d;

  logic [NumReq-1:0]  eligible;
  logic               any_eligible;
  logic [IdWidth-1:0] grant;
  logic               issue;
  logic               tag_ok;
  logic               bad_tag;
  logic [NumReq-1:0]  rsp_hs;

  // A requester may only compete while it still has credit left.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NumReq; i++) begin
      eligible[i] = req_valid_i[i] && (cnt_q[i] < MaxCnt);
    end
  end

  // Round-robin search starting just after the last winner. Offsets are
  // walked from farthest to nearest so the nearest eligible one wins.
  always_comb begin
    logic [IdWidth-1:0] idx;
    idx          = '0;
    grant        = '0;
    any_eligible = 1'b0;
    for (int unsigned k = NumReq; k >= 1; k--) begin
      idx = IdWidth'((32'(rr_q) + k) % NumReq);
      if (eligible[idx]) begin
        grant        = idx;
        any_eligible = 1'b1;
      end
    end
  end

  // Valid never looks at fpu_ready_i, so there is no ready->valid loop.
  assign fpu_valid_o = any_eligible && !flush_i;
  assign fpu_data_o  = req_data_i[grant];
  assign fpu_tag_o   = grant;
  assign issue       = fpu_valid_o && fpu_ready_i;

  always_comb begin
    req_ready_o = '0;
    for (int i = 0; i < NumReq; i++) begin
      req_ready_o[i] = issue && (grant == IdWidth'(i));
    end
  end

  // Tags outside the requester range are swallowed so the FPU cannot stall.
  assign tag_ok          = (32'(fpu_tag_i) < NumReq);
  assign bad_tag         = fpu_out_valid_i && !tag_ok;
  assign rsp_data_o      = fpu_result_i;
  assign fpu_out_ready_o = tag_ok ? rsp_ready_i[fpu_tag_i] : 1'b1;

  always_comb begin
    rsp_valid_o = '0;
    rsp_hs      = '0;
    for (int i = 0; i < NumReq; i++) begin
      rsp_valid_o[i] = fpu_out_valid_i && tag_ok && (fpu_tag_i == IdWidth'(i));
      rsp_hs[i]      = rsp_valid_o[i] && rsp_ready_i[i];
    end
  end

  // Credit bookkeeping. An issue and a return for the same requester in one
  // cycle cancel out. A return with no credit in use is still delivered but
  // flagged. Flush wipes the counters and freezes pointer and error flag.
  always_comb begin
    logic iss_i;
    iss_i = 1'b0;
    cnt_d = cnt_q;
    rr_d  = rr_q;
    err_d = err_q;
    if (flush_i) begin
      cnt_d = '0;
    end else begin
      if (issue) rr_d = grant;
      if (bad_tag) err_d = 1'b1;
      for (int i = 0; i < NumReq; i++) begin
        iss_i = issue && (grant == IdWidth'(i));
        if (iss_i && !rsp_hs[i]) begin
          cnt_d[i] = cnt_q[i] + cnt_t'(1);
        end else if (!iss_i && rsp_hs[i]) begin
          if (cnt_q[i] == '0) err_d = 1'b1;
          else                cnt_d[i] = cnt_q[i] - cnt_t'(1);
        end
      end
    end
  end

  // Pointer resets to the last requester so requester 0 is searched first.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      rr_q  <= IdWidth'(NumReq - 1);
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      rr_q  <= rr_d;
      err_q <= err_d;
    end
  end

  always_comb begin
    busy_o = 1'b0;
    for (int i = 0; i < NumReq; i++) begin
      busy_o = busy_o || (cnt_q[i] != '0);
    end
  end

  assign err_o = err_q;

endmodule

// File: tb/tb_fpnew_opgroup_dispatcher.sv
// tb_fpnew_opgroup_dispatcher
//
// Directed bench for the opgroup dispatcher, configured with three
// requesters and two credits each so arbitration order, credit exhaustion,
// bad tags and flush can all be exercised on one instance. Inputs change
// just after the falling edge and outputs are compared 1 ns later.
module tb_fpnew_opgroup_dispatcher;

  localparam int unsigned NumReq = 3;
  localparam int unsigned PW     = 16;
  localparam int unsigned RW     = 8;
  localparam int unsigned MaxOut = 2;

  logic                     clk;
  logic                     rst_n;
  logic [NumReq-1:0]        req_valid;
  logic [NumReq-1:0]        req_ready;
  logic [NumReq-1:0][PW-1:0] req_data;
  logic                     fpu_valid;
  logic                     fpu_ready;
  logic [PW-1:0]            fpu_data;
  logic [1:0]               fpu_tag;
  logic                     fpu_out_valid;
  logic                     fpu_out_ready;
  logic [RW-1:0]            fpu_result;
  logic [1:0]               fpu_tag_in;
  logic [NumReq-1:0]        rsp_valid;
  logic [NumReq-1:0]        rsp_ready;
  logic [RW-1:0]            rsp_data;
  logic                     flush;
  logic                     busy;
  logic                     err;

  int tests;
  int failures;

  fpnew_opgroup_dispatcher #(
    .NumReq(NumReq), .PayloadWidth(PW), .ResWidth(RW), .MaxOutstanding(MaxOut)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_data_i(req_data),
    .fpu_valid_o(fpu_valid), .fpu_ready_i(fpu_ready),
    .fpu_data_o(fpu_data), .fpu_tag_o(fpu_tag),
    .fpu_out_valid_i(fpu_out_valid), .fpu_out_ready_o(fpu_out_ready),
    .fpu_result_i(fpu_result), .fpu_tag_i(fpu_tag_in),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data),
    .flush_i(flush), .busy_o(busy), .err_o(err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic idle();
    req_valid     = '0;
    fpu_ready     = 1'b0;
    fpu_out_valid = 1'b0;
    fpu_tag_in    = '0;
    fpu_result    = '0;
    rsp_ready     = '0;
    flush         = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    @(negedge clk); #1;
    tests++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL rst_busy got %b expected 0", busy); end
    tests++; if (fpu_valid !== 1'b0) begin failures++; $display("[TB] FAIL rst_fpu_valid got %b expected 0", fpu_valid); end
    tests++; if (req_ready !== 3'b000) begin failures++; $display("[TB] FAIL rst_req_ready got %b expected 000", req_ready); end
    tests++; if (err !== 1'b0) begin failures++; $display("[TB] FAIL rst_err got %b expected 0", err); end
    req_valid = 3'b010; fpu_ready = 1'b1; #1;
    tests++; if (fpu_valid !== 1'b1) begin failures++; $display("[TB] FAIL rst_grant_valid got %b expected 1", fpu_valid); end
    tests++; if (fpu_tag !== 2'd1) begin failures++; $display("[TB] FAIL rst_grant_tag got %0d expected 1", fpu_tag); end
    tests++; if (req_ready !== 3'b010) begin failures++; $display("[TB] FAIL rst_grant_ready got %b expected 010", req_ready); end
    tests++; if (fpu_data !== 16'hA111) begin failures++; $display("[TB] FAIL rst_grant_data got %h expected a111", fpu_data); end
    @(negedge clk);
    idle();
    rst_n = 1'b1;
  endtask

  // Requesters 0 and 1 both valid every cycle: grants must alternate.
  task automatic test_fairness();
    logic [1:0] exp_tag;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      req_valid = 3'b011; fpu_ready = 1'b1; #1;
      exp_tag = 2'(c % 2);
      tests++; if (fpu_tag !== exp_tag) begin failures++; $display("[TB] FAIL fair_tag%0d got %0d expected %0d", c, fpu_tag, exp_tag); end
      tests++; if (req_ready !== (3'b001 << exp_tag)) begin failures++; $display("[TB] FAIL fair_ready%0d got %b expected %b", c, req_ready, 3'b001 << exp_tag); end
      tests++; if (fpu_data !== (16'hA000 + 16'h0111 * 16'(exp_tag))) begin failures++; $display("[TB] FAIL fair_data%0d got %h expected %h", c, fpu_data, 16'hA000 + 16'h0111 * 16'(exp_tag)); end
    end
    // Both now hold two credits each: nobody is eligible.
    @(negedge clk); #1;
    tests++; if (fpu_valid !== 1'b0) begin failures++; $display("[TB] FAIL fair_exhaust_valid got %b expected 0", fpu_valid); end
    tests++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL fair_busy got %b expected 1", busy); end
    @(negedge clk);
    idle(); flush = 1'b1; #1;
    tests++; if (fpu_valid !== 1'b0) begin failures++; $display("[TB] FAIL fair_flush_valid got %b expected 0", fpu_valid); end
    @(negedge clk);
    idle(); #1;
    tests++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL fair_flush_busy got %b expected 0", busy); end
  endtask

  // Requester 0 alone: two issues, then blocked while requester 1 is served.
  task automatic test_credit_limit();
    logic [2:0] exp_ready [3] = '{3'b001, 3'b001, 3'b000};
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      req_valid = 3'b001; fpu_ready = 1'b1; #1;
      tests++; if (req_ready !== exp_ready[c]) begin failures++; $display("[TB] FAIL credit_ready%0d got %b expected %b", c, req_ready, exp_ready[c]); end
    end
    tests++; if (fpu_valid !== 1'b0) begin failures++; $display("[TB] FAIL credit_valid got %b expected 0", fpu_valid); end
    tests++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL credit_busy got %b expected 1", busy); end
    @(negedge clk);
    req_valid = 3'b011; fpu_ready = 1'b1; #1;
    tests++; if (fpu_tag !== 2'd1) begin failures++; $display("[TB] FAIL credit_other_tag got %0d expected 1", fpu_tag); end
    tests++; if (req_ready !== 3'b010) begin failures++; $display("[TB] FAIL credit_other_ready got %b expected 010", req_ready); end
    @(negedge clk);
    idle();
  endtask

  // cnt[1]=1; issue and return for 1 in one cycle must leave it at 1,
  // so exactly one more issue to 1 fits before it is blocked.
  task automatic test_back_to_back();
    req_valid = 3'b010; fpu_ready = 1'b1;
    fpu_out_valid = 1'b1; fpu_tag_in = 2'd1; rsp_ready = 3'b010; fpu_result = 8'h5A; #1;
    tests++; if (req_ready !== 3'b010) begin failures++; $display("[TB] FAIL b2b_req_ready got %b expected 010", req_ready); end
    tests++; if (rsp_valid !== 3'b010) begin failures++; $display("[TB] FAIL b2b_rsp_valid got %b expected 010", rsp_valid); end
    tests++; if (rsp_data !== 8'h5A) begin failures++; $display("[TB] FAIL b2b_rsp_data got %h expected 5a", rsp_data); end
    tests++; if (fpu_out_ready !== 1'b1) begin failures++; $display("[TB] FAIL b2b_out_ready got %b expected 1", fpu_out_ready); end
    @(negedge clk);
    idle(); req_valid = 3'b010; fpu_ready = 1'b1; #1;
    tests++; if (req_ready !== 3'b010) begin failures++; $display("[TB] FAIL b2b_second_issue got %b expected 010", req_ready); end
    @(negedge clk); #1;
    tests++; if (req_ready !== 3'b000) begin failures++; $display("[TB] FAIL b2b_blocked got %b expected 000", req_ready); end
    @(negedge clk);
    idle();
  endtask

  // Result for 0 stalled three cycles, accepted on the fourth: one credit back.
  task automatic test_backpressure();
    for (int c = 0; c < 4; c++) begin
      fpu_out_valid = 1'b1; fpu_tag_in = 2'd0; fpu_result = 8'hC3;
      rsp_ready = (c == 3) ? 3'b001 : 3'b000; #1;
      tests++; if (rsp_valid !== 3'b001) begin failures++; $display("[TB] FAIL bp_rsp_valid%0d got %b expected 001", c, rsp_valid); end
      tests++; if (fpu_out_ready !== (c == 3)) begin failures++; $display("[TB] FAIL bp_out_ready%0d got %b expected %b", c, fpu_out_ready, c == 3); end
      @(negedge clk);
    end
    idle(); req_valid = 3'b001; fpu_ready = 1'b1; #1;
    tests++; if (req_ready !== 3'b001) begin failures++; $display("[TB] FAIL bp_reissue got %b expected 001", req_ready); end
    @(negedge clk); #1;
    tests++; if (req_ready !== 3'b000) begin failures++; $display("[TB] FAIL bp_reblocked got %b expected 000", req_ready); end
    @(negedge clk);
    idle();
  endtask

  task automatic test_bad_tag();
    fpu_out_valid = 1'b1; fpu_tag_in = 2'd3; fpu_result = 8'hFF; rsp_ready = 3'b000; #1;
    tests++; if (fpu_out_ready !== 1'b1) begin failures++; $display("[TB] FAIL bad_out_ready got %b expected 1", fpu_out_ready); end
    tests++; if (rsp_valid !== 3'b000) begin failures++; $display("[TB] FAIL bad_rsp_valid got %b expected 000", rsp_valid); end
    tests++; if (err !== 1'b0) begin failures++; $display("[TB] FAIL bad_err_early got %b expected 0", err); end
    @(negedge clk);
    idle(); #1;
    tests++; if (err !== 1'b1) begin failures++; $display("[TB] FAIL bad_err got %b expected 1", err); end
  endtask

  // Bring counts to {2,1,0}, then flush while a result passes through.
  task automatic test_flush();
    @(negedge clk);
    fpu_out_valid = 1'b1; fpu_tag_in = 2'd1; rsp_ready = 3'b010; #1;
    tests++; if (rsp_valid !== 3'b010) begin failures++; $display("[TB] FAIL flush_pre_rsp got %b expected 010", rsp_valid); end
    @(negedge clk);
    idle(); flush = 1'b1; req_valid = 3'b111; fpu_ready = 1'b1;
    fpu_out_valid = 1'b1; fpu_tag_in = 2'd0; rsp_ready = 3'b001; fpu_result = 8'h11; #1;
    tests++; if (fpu_valid !== 1'b0) begin failures++; $display("[TB] FAIL flush_valid got %b expected 0", fpu_valid); end
    tests++; if (req_ready !== 3'b000) begin failures++; $display("[TB] FAIL flush_req_ready got %b expected 000", req_ready); end
    tests++; if (rsp_valid !== 3'b001) begin failures++; $display("[TB] FAIL flush_rsp_valid got %b expected 001", rsp_valid); end
    tests++; if (fpu_out_ready !== 1'b1) begin failures++; $display("[TB] FAIL flush_out_ready got %b expected 1", fpu_out_ready); end
    @(negedge clk);
    idle(); req_valid = 3'b111; #1;
    tests++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL flush_busy got %b expected 0", busy); end
    tests++; if (err !== 1'b1) begin failures++; $display("[TB] FAIL flush_err got %b expected 1", err); end
    tests++; if (fpu_tag !== 2'd1) begin failures++; $display("[TB] FAIL flush_rr_hold got %0d expected 1", fpu_tag); end
    @(negedge clk);
    idle();
  endtask

  // Reset with work in flight, then a late result hits a zero counter.
  task automatic test_reset_midop();
    req_valid = 3'b001; fpu_ready = 1'b1;
    @(negedge clk);
    idle(); #1;
    tests++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL mid_busy got %b expected 1", busy); end
    rst_n = 1'b0; #1;
    tests++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL mid_rst_busy got %b expected 0", busy); end
    tests++; if (err !== 1'b0) begin failures++; $display("[TB] FAIL mid_rst_err got %b expected 0", err); end
    @(negedge clk);
    rst_n = 1'b1;
    fpu_out_valid = 1'b1; fpu_tag_in = 2'd2; rsp_ready = 3'b100; fpu_result = 8'h77; #1;
    tests++; if (rsp_valid !== 3'b100) begin failures++; $display("[TB] FAIL late_rsp_valid got %b expected 100", rsp_valid); end
    tests++; if (rsp_data !== 8'h77) begin failures++; $display("[TB] FAIL late_rsp_data got %h expected 77", rsp_data); end
    @(negedge clk);
    idle(); #1;
    tests++; if (err !== 1'b1) begin failures++; $display("[TB] FAIL late_err got %b expected 1", err); end
    tests++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL late_busy got %b expected 0", busy); end
  endtask

  // All three valid: a stalled first cycle must not move the pointer,
  // then grants rotate 0,1,2,0,1,2 until every credit is used.
  task automatic test_rotation();
    req_valid = 3'b111; fpu_ready = 1'b0; #1;
    tests++; if (fpu_valid !== 1'b1) begin failures++; $display("[TB] FAIL rot_stall_valid got %b expected 1", fpu_valid); end
    tests++; if (req_ready !== 3'b000) begin failures++; $display("[TB] FAIL rot_stall_ready got %b expected 000", req_ready); end
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      req_valid = 3'b111; fpu_ready = 1'b1; #1;
      tests++; if (fpu_tag !== 2'(c % 3)) begin failures++; $display("[TB] FAIL rot_tag%0d got %0d expected %0d", c, fpu_tag, c % 3); end
    end
    @(negedge clk); #1;
    tests++; if (fpu_valid !== 1'b0) begin failures++; $display("[TB] FAIL rot_full_valid got %b expected 0", fpu_valid); end
    @(negedge clk);
    idle();
  endtask

  initial begin
    tests    = 0;
    failures = 0;
    req_data[0] = 16'hA000;
    req_data[1] = 16'hA111;
    req_data[2] = 16'hA222;
    test_reset();
    test_fairness();
    test_credit_limit();
    test_back_to_back();
    test_backpressure();
    test_bad_tag();
    test_flush();
    test_reset_midop();
    test_rotation();
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
